// File: rtl/aes_round_seq.sv
// Iterative AES-128 cipher sequencer: drives one combinational aesround datapath
// through the initial AddRoundKey and rounds 1..NR, with valid/ready on both sides.
module aes_round_seq #(
    parameter int NR    = 10,
    parameter int CNT_W = 16
) (
    input  logic             eph1,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic [3:0]       rk_idx,
    input  logic [127:0]     rk_data,
    input  logic             rk_valid,
    output logic [127:0]     dp_round_in,
    output logic [127:0]     dp_key_words,
    output logic [NR:0]      dp_fin_counter_in,
    input  logic [127:0]     dp_round_out,
    input  logic [NR:0]      dp_fin_counter_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [CNT_W-1:0] blk_cnt
);
    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_e;

    // One-hot marker for round 1; the datapath shifts it left once per round.
    localparam logic [NR:0] RND_FIRST = {{(NR - 1){1'b0}}, 2'b10};

    state_e           state_q;
    logic [127:0]     st_q;
    logic [NR:0]      rnd_q;
    logic [3:0]       rk_idx_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] blk_cnt_q;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let st_q/rnd_q see each other's new value.
    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            st_q        <= '0;
            rnd_q       <= '0;
            rk_idx_q    <= '0;
            out_valid_q <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && rk_valid) begin
                        st_q     <= in_data ^ rk_data;
                        rnd_q    <= RND_FIRST;
                        rk_idx_q <= 4'd1;
                        state_q  <= ROUND;
                    end
                end
                ROUND: begin
                    // A missing round key freezes the whole block in place.
                    if (rk_valid) begin
                        st_q  <= dp_round_out;
                        rnd_q <= dp_fin_counter_out;
                        if (rnd_q[NR]) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            rk_idx_q    <= '0;
                        end else begin
                            rk_idx_q <= rk_idx_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        blk_cnt_q   <= blk_cnt_q + CNT_W'(1);
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Key store lookup is the only combinational path into the datapath.
    assign in_ready          = (state_q == IDLE) && rk_valid;
    assign rk_idx            = rk_idx_q;
    assign dp_round_in       = st_q;
    assign dp_key_words      = rk_data;
    assign dp_fin_counter_in = rnd_q;
    assign out_valid         = out_valid_q;
    assign out_data          = st_q;
    assign blk_cnt           = blk_cnt_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Scoreboard bench for aes_round_seq: behavioural AES-128 key store, round datapath
// and reference cipher; monitor pops expected ciphertexts on every output handshake.
`timescale 1ns/1ps
module tb_aes_round_seq;
    localparam int CNT_W = 2;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             eph1 = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [3:0]       rk_idx;
    logic [127:0]     rk_data;
    logic             rk_valid;
    logic [127:0]     dp_round_in;
    logic [127:0]     dp_key_words;
    logic [10:0]      dp_fin_counter_in;
    logic [127:0]     dp_round_out;
    logic [10:0]      dp_fin_counter_out;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic [CNT_W-1:0] blk_cnt;

    always #5 eph1 = ~eph1;

    aes_round_seq #(.NR(10), .CNT_W(CNT_W)) dut (
        .eph1              (eph1),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .rk_idx            (rk_idx),
        .rk_data           (rk_data),
        .rk_valid          (rk_valid),
        .dp_round_in       (dp_round_in),
        .dp_key_words      (dp_key_words),
        .dp_fin_counter_in (dp_fin_counter_in),
        .dp_round_out      (dp_round_out),
        .dp_fin_counter_out(dp_fin_counter_out),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .blk_cnt           (blk_cnt)
    );

    // ---------------- AES reference (FIPS-197 byte 0 = bits [127:120]) ----------------
    logic [7:0]   sbox [256];
    logic [127:0] rkeys [11];
    bit           sbox_ready = 1'b0;
    int           key_gen = 0;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} >> (8 - n);
        return t[7:0];
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8), then affine map.
    function automatic void build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input bit last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                t[row + 4*c] = b[row + 4*((c + row) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r ^ k;
    endfunction

    function automatic void expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        key_gen++;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rkeys[0];
        for (int r = 1; r <= 10; r++) s = aes_round(s, rkeys[r], r == 10);
        return s;
    endfunction

    // External key store and combinational datapath seen by the DUT.
    always @(rk_idx or key_gen)
        rk_data = (rk_idx <= 4'd10) ? rkeys[rk_idx] : 128'h0;

    always @(dp_round_in or dp_key_words or dp_fin_counter_in or sbox_ready) begin
        dp_round_out       = aes_round(dp_round_in, dp_key_words, dp_fin_counter_in[10]);
        dp_fin_counter_out = dp_fin_counter_in << 1;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0] data;
        int           lat;
        time          acc_t;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   failures = 0;
    int   model_cnt = 0;
    bit   cnt_pending = 1'b0;
    bit   prev_valid = 1'b0;
    time  last_hs_t = 0;
    time  last_acc_t = 0;
    time  prev_acc_t = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge eph1) begin
        if (reset) begin
            prev_valid  = 1'b0;
            cnt_pending = 1'b0;
        end else begin
            if (cnt_pending) begin
                check("blk_cnt", 128'(blk_cnt), 128'(model_cnt % (1 << CNT_W)));
                cnt_pending = 1'b0;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %h with no block outstanding", out_data);
                end else begin
                    if (!prev_valid)
                        check("latency", 128'(($time - 5 - exp_q[0].acc_t) / 10), 128'(exp_q[0].lat));
                    check("out_data", out_data, exp_q[0].data);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        model_cnt++;
                        cnt_pending = 1'b1;
                        last_hs_t   = $time + 5;
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [127:0] pt, input logic [127:0] exp, input int lat);
        exp_t e;
        int   n;
        n = 0;
        in_data  = pt;
        in_valid = 1'b1;
        forever begin
            @(negedge eph1);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", n);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge eph1);
        e.data  = exp;
        e.lat   = lat;
        e.acc_t = $time;
        exp_q.push_back(e);
        prev_acc_t = last_acc_t;
        last_acc_t = $time;
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 || out_valid) begin
            @(negedge eph1);
            n++;
            if (n > 300) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout: %0d blocks outstanding, required 0", exp_q.size());
                break;
            end
        end
        @(posedge eph1);
        #1;
    endtask

    logic [127:0] bp2;

    initial begin
        logic [127:0] exp_st;
        logic [127:0] pt;
        int           n;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        rk_valid  = 1'b1;
        build_sbox();
        sbox_ready = 1'b1;
        expand_key(KEY_B);
        repeat (2) @(posedge eph1);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_rk_idx", 128'(rk_idx), 128'(0));
        check("rst_dp_round_in", dp_round_in, 128'h0);
        check("rst_fin_counter", 128'(dp_fin_counter_in), 128'(0));
        check("rst_out_data", out_data, 128'h0);
        check("rst_blk_cnt", 128'(blk_cnt), 128'(0));
        check("rst_in_ready_hi", 128'(in_ready), 128'(1));
        rk_valid = 1'b0;
        #1 check("rst_in_ready_lo", 128'(in_ready), 128'(0));
        rk_valid = 1'b1;
        @(posedge eph1);
        #1 reset = 1'b0;

        // FIPS-197 Appendix B
        send(PT_B, CT_B, 10);
        wait_idle();
        check("appb_blk_cnt", 128'(blk_cnt), 128'(1));

        // FIPS-197 Appendix C.1 with key-index / round-counter trace
        expand_key(KEY_C);
        check("c1_idle_rk_idx", 128'(rk_idx), 128'(0));
        send(PT_C, CT_C, 10);
        for (int k = 1; k <= 10; k++) begin
            @(negedge eph1);
            check("c1_rk_idx", 128'(rk_idx), 128'(k));
            check("c1_fin_counter", 128'(dp_fin_counter_in), 128'(1) << k);
        end
        wait_idle();

        // Output backpressure with a second block offered while DONE
        expand_key(KEY_B);
        out_ready = 1'b0;
        send(PT_B, CT_B, 10);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge eph1);
            n++;
        end
        check("bp_out_valid_seen", 128'(out_valid), 128'(1));
        @(posedge eph1);
        #1;
        bp2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        fork
            send(bp2, aes_encrypt(bp2), 10);
        join_none
        for (int i = 0; i < 5; i++) begin
            @(negedge eph1);
            check("bp_in_ready", 128'(in_ready), 128'(0));
            check("bp_out_valid", 128'(out_valid), 128'(1));
        end
        @(posedge eph1);
        #1 out_ready = 1'b1;
        @(posedge eph1);
        @(negedge eph1);
        check("bp_idle_out_valid", 128'(out_valid), 128'(0));
        check("bp_idle_in_ready", 128'(in_ready), 128'(1));
        wait fork;
        check("bp_accept_gap", 128'((last_acc_t - last_hs_t) / 10), 128'(1));
        wait_idle();

        // Key stall: rk_valid low for 3 cycles during round 4
        exp_st = PT_B ^ rkeys[0];
        for (int r = 1; r <= 3; r++) exp_st = aes_round(exp_st, rkeys[r], 1'b0);
        send(PT_B, CT_B, 13);
        repeat (3) @(posedge eph1);
        #1 rk_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge eph1);
            check("stall_rk_idx", 128'(rk_idx), 128'(4));
            check("stall_state", dp_round_in, exp_st);
            check("stall_fin_counter", 128'(dp_fin_counter_in), 128'(11'h010));
        end
        @(posedge eph1);
        #1 rk_valid = 1'b1;
        wait_idle();

        // No key material in IDLE: offer must not be taken
        rk_valid = 1'b0;
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge eph1);
            check("idle_nokey_in_ready", 128'(in_ready), 128'(0));
        end
        @(posedge eph1);
        #1;
        in_valid = 1'b0;
        rk_valid = 1'b1;

        // Reset during round 6 aborts the block
        send(PT_B, CT_B, 10);
        repeat (5) @(posedge eph1);
        #1 reset = 1'b1;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_rk_idx", 128'(rk_idx), 128'(0));
        check("midrst_blk_cnt", 128'(blk_cnt), 128'(0));
        check("midrst_dp_round_in", dp_round_in, 128'h0);
        exp_q.delete();
        model_cnt = 0;
        repeat (2) @(posedge eph1);
        #1 reset = 1'b0;
        send(PT_B, CT_B, 10);
        wait_idle();
        check("postrst_blk_cnt", 128'(blk_cnt), 128'(1));

        // Counter wrap: fresh reset, random key, 5 back-to-back random blocks
        reset = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        @(posedge eph1);
        #1 reset = 1'b0;
        expand_key({$urandom(), $urandom(), $urandom(), $urandom()});
        for (int i = 0; i < 5; i++) begin
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(pt, aes_encrypt(pt), 10);
            if (i > 0) check("throughput", 128'((last_acc_t - prev_acc_t) / 10), 128'(12));
        end
        wait_idle();
        check("wrap_blk_cnt", 128'(blk_cnt), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
